// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, fetch-buffer entry layout and slot-mask helper for the
// instruction fetch sequencer.
package fetch_ctrl_pkg;
  localparam int RV32_ADDR_WIDTH  = 32;
  localparam int IMEM_DATA_WIDTH  = 64;
  localparam int IMEM_ADDR_WIDTH  = 10;
  localparam int FETCH_BYTES_LOG2 = 3;
  localparam int FETCH_WIDTH      = 1 << (FETCH_BYTES_LOG2 - 2);
  localparam int SLOT_W           = FETCH_BYTES_LOG2 - 2;

  typedef logic [RV32_ADDR_WIDTH-1:0] addr_t;
  typedef logic [IMEM_DATA_WIDTH-1:0] blk_t;
  typedef logic [FETCH_WIDTH-1:0]     mask_t;

  typedef struct packed {
    addr_t pc;
    blk_t  data;
    mask_t mask;
  } fetch_entry_t;

  // Slots at or after the entry slot of the block are live.
  function automatic mask_t slot_mask(logic [SLOT_W-1:0] slot);
    mask_t m;
    m = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) m[i] = (i >= int'(slot));
    return m;
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// imem, redirect and decode-side signals of the fetch sequencer.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  addr_t o_imem_addr;
  blk_t  i_imem_rd_data;
  logic  i_redirect_valid;
  addr_t i_redirect_pc;
  logic  o_fetch_valid;
  logic  i_fetch_ready;
  addr_t o_fetch_pc;
  blk_t  o_fetch_data;
  mask_t o_fetch_slot_mask;

  modport master (
    output o_imem_addr,
    input  i_imem_rd_data,
    input  i_redirect_valid,
    input  i_redirect_pc,
    output o_fetch_valid,
    input  i_fetch_ready,
    output o_fetch_pc,
    output o_fetch_data,
    output o_fetch_slot_mask
  );

  modport slave (
    input  o_imem_addr,
    output i_imem_rd_data,
    output i_redirect_valid,
    output i_redirect_pc,
    input  o_fetch_valid,
    output i_fetch_ready,
    input  o_fetch_pc,
    input  o_fetch_data,
    input  o_fetch_slot_mask
  );
endinterface

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO with flush; head reads as zero when empty.
module fetch_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
    !(push && !pop_ok && count_q == 2'd2));
`endif
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, tracks the one-cycle imem read and
// buffers returned blocks for decode; redirects flush everything in flight.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t RESET_PC         = 32'h0000_0000,
  parameter int    FETCH_BYTES_LOG2 = fetch_ctrl_pkg::FETCH_BYTES_LOG2,
  parameter int    FETCH_WIDTH      = 1 << (FETCH_BYTES_LOG2 - 2)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);
  localparam addr_t BLK_BYTES = addr_t'(1) << FETCH_BYTES_LOG2;

  addr_t        pc_q, pc_d;
  addr_t        infl_pc_q, infl_pc_d;
  logic         infl_q, infl_d;
  logic [1:0]   count;
  logic         valid, pop, issue, redirect;
  logic [2:0]   occ;
  logic [FETCH_WIDTH-1:0] push_mask;
  fetch_entry_t push_entry, head;

  assign redirect = bus.i_redirect_valid;
  assign valid    = (count != 2'd0);
  assign pop      = valid && bus.i_fetch_ready;

  // Occupancy after this cycle's pop, counting the block still in flight.
  assign occ   = {1'b0, count} + {2'b0, infl_q} - {2'b0, pop};
  assign issue = !redirect && (occ < 3'd2);

  always_comb begin
    pc_d      = pc_q;
    infl_d    = 1'b0;
    infl_pc_d = infl_pc_q;
    if (redirect) begin
      pc_d = bus.i_redirect_pc;
    end else if (issue) begin
      infl_d    = 1'b1;
      infl_pc_d = pc_q;
      pc_d      = (pc_q & ~(BLK_BYTES - addr_t'(1))) + BLK_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  assign push_mask  = slot_mask(infl_pc_q[FETCH_BYTES_LOG2-1:2]);
  assign push_entry = '{pc: infl_pc_q, data: bus.i_imem_rd_data, mask: push_mask};

  fetch_buf #(.W($bits(fetch_entry_t))) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (infl_q),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign bus.o_imem_addr       = pc_q >> FETCH_BYTES_LOG2;
  assign bus.o_fetch_valid     = valid;
  assign bus.o_fetch_pc        = head.pc;
  assign bus.o_fetch_data      = head.data;
  assign bus.o_fetch_slot_mask = head.mask;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; imem model returns the block index as data.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.i_imem_rd_data <= 64'(bus.o_imem_addr[IMEM_ADDR_WIDTH-1:0]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_fetch_ready    = 1'b1;
    tick(); tick();
    chk("rst_valid", bus.o_fetch_valid, 0);
    chk("rst_addr",  bus.o_imem_addr, 0);
    chk("rst_pc",    bus.o_fetch_pc, 0);
    chk("rst_data",  bus.o_fetch_data, 0);
    chk("rst_mask",  bus.o_fetch_slot_mask, 0);

    // 1: streaming from reset
    reset = 1'b0;
    chk("t1_R_addr", bus.o_imem_addr, 0);
    tick();
    chk("t1_R1_valid", bus.o_fetch_valid, 0);
    chk("t1_R1_addr",  bus.o_imem_addr, 1);
    tick();
    chk("t1_R2_valid", bus.o_fetch_valid, 1);
    chk("t1_R2_pc",    bus.o_fetch_pc, 32'h0);
    chk("t1_R2_data",  bus.o_fetch_data, 0);
    chk("t1_R2_mask",  bus.o_fetch_slot_mask, 2'b11);
    chk("t1_R2_addr",  bus.o_imem_addr, 2);
    tick();
    chk("t1_R3_pc",   bus.o_fetch_pc, 32'h8);
    chk("t1_R3_data", bus.o_fetch_data, 1);
    tick();
    chk("t1_R4_pc",   bus.o_fetch_pc, 32'h10);
    chk("t1_R4_data", bus.o_fetch_data, 2);

    // 2: backpressure for 5 cycles from R+2
    do_reset();
    tick(); tick();
    bus.i_fetch_ready = 1'b0;
    chk("t2_R2_valid", bus.o_fetch_valid, 1);
    chk("t2_R2_data",  bus.o_fetch_data, 0);
    tick();
    chk("t2_R3_addr", bus.o_imem_addr, 2);
    chk("t2_R3_data", bus.o_fetch_data, 0);
    tick(); tick(); tick();
    chk("t2_R6_addr",  bus.o_imem_addr, 2);
    chk("t2_R6_data",  bus.o_fetch_data, 0);
    chk("t2_R6_valid", bus.o_fetch_valid, 1);
    tick();
    bus.i_fetch_ready = 1'b1;
    chk("t2_R7_data", bus.o_fetch_data, 0);
    tick();
    chk("t2_R8_data", bus.o_fetch_data, 1);
    chk("t2_R8_addr", bus.o_imem_addr, 3);
    tick();
    chk("t2_R9_data", bus.o_fetch_data, 2);
    tick();
    chk("t2_R10_data", bus.o_fetch_data, 3);
    chk("t2_R10_pc",   bus.o_fetch_pc, 32'h18);

    // 3: redirect to a slot-1 PC while the buffer is full
    do_reset();
    bus.i_fetch_ready = 1'b0;
    tick(); tick(); tick();
    chk("t3_full_valid", bus.o_fetch_valid, 1);
    chk("t3_full_addr",  bus.o_imem_addr, 2);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h104;
    tick();
    bus.i_redirect_valid = 1'b0;
    chk("t3_rd1_valid", bus.o_fetch_valid, 0);
    chk("t3_rd1_addr",  bus.o_imem_addr, 32'h20);
    tick();
    chk("t3_rd2_valid", bus.o_fetch_valid, 0);
    tick();
    chk("t3_rd3_valid", bus.o_fetch_valid, 1);
    chk("t3_rd3_pc",    bus.o_fetch_pc, 32'h104);
    chk("t3_rd3_mask",  bus.o_fetch_slot_mask, 2'b10);
    chk("t3_rd3_data",  bus.o_fetch_data, 32'h20);
    bus.i_fetch_ready = 1'b1;
    tick();
    chk("t3_rd4_pc",   bus.o_fetch_pc, 32'h108);
    chk("t3_rd4_mask", bus.o_fetch_slot_mask, 2'b11);
    chk("t3_rd4_data", bus.o_fetch_data, 32'h21);

    // 4: redirect with a pop and an in-flight capture in the same cycle
    do_reset();
    tick(); tick(); tick();
    chk("t4_pre_pc", bus.o_fetch_pc, 32'h8);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h200;
    tick();
    bus.i_redirect_valid = 1'b0;
    chk("t4_rd1_valid", bus.o_fetch_valid, 0);
    chk("t4_rd1_addr",  bus.o_imem_addr, 32'h40);
    tick();
    chk("t4_rd2_valid", bus.o_fetch_valid, 0);
    tick();
    chk("t4_rd3_pc",   bus.o_fetch_pc, 32'h200);
    chk("t4_rd3_data", bus.o_fetch_data, 32'h40);
    chk("t4_rd3_mask", bus.o_fetch_slot_mask, 2'b11);
    tick();
    chk("t4_rd4_pc",   bus.o_fetch_pc, 32'h208);
    chk("t4_rd4_data", bus.o_fetch_data, 32'h41);

    // 5: back-to-back redirects, last one wins
    do_reset();
    tick(); tick(); tick();
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h40;
    tick();
    bus.i_redirect_pc    = 32'h80;
    chk("t5_rd1_valid", bus.o_fetch_valid, 0);
    tick();
    bus.i_redirect_valid = 1'b0;
    chk("t5_rd2_valid", bus.o_fetch_valid, 0);
    chk("t5_rd2_addr",  bus.o_imem_addr, 32'h10);
    tick();
    chk("t5_rd3_valid", bus.o_fetch_valid, 0);
    tick();
    chk("t5_rd4_pc",   bus.o_fetch_pc, 32'h80);
    chk("t5_rd4_data", bus.o_fetch_data, 32'h10);
    tick();
    chk("t5_rd5_pc",   bus.o_fetch_pc, 32'h88);
    chk("t5_rd5_data", bus.o_fetch_data, 32'h11);

    // 6: reset with a full buffer
    do_reset();
    bus.i_fetch_ready = 1'b0;
    tick(); tick(); tick();
    chk("t6_full_valid", bus.o_fetch_valid, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", bus.o_fetch_valid, 0);
    chk("t6_rst_addr",  bus.o_imem_addr, 0);
    chk("t6_rst_data",  bus.o_fetch_data, 0);
    reset = 1'b0;
    bus.i_fetch_ready = 1'b1;
    tick(); tick();
    chk("t6_R2_valid", bus.o_fetch_valid, 1);
    chk("t6_R2_pc",    bus.o_fetch_pc, 32'h0);
    chk("t6_R2_data",  bus.o_fetch_data, 0);

    // 7: PC wraps past the top of the address space
    do_reset();
    tick();
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.i_redirect_valid = 1'b0;
    chk("t7_addr", bus.o_imem_addr, 32'h1FFF_FFFF);
    tick(); tick();
    chk("t7_top_pc",   bus.o_fetch_pc, 32'hFFFF_FFFC);
    chk("t7_top_mask", bus.o_fetch_slot_mask, 2'b10);
    chk("t7_top_data", bus.o_fetch_data, 32'h3FF);
    tick();
    chk("t7_wrap_pc",   bus.o_fetch_pc, 32'h0);
    chk("t7_wrap_mask", bus.o_fetch_slot_mask, 2'b11);
    chk("t7_wrap_data", bus.o_fetch_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
